// File: rtl/lpa_issue_ctrl.sv
// lpa_issue_ctrl: issue stage for the LowPowerArithmetic datapath.
// Buffers requests in a FIFO and drives them to an external combinational
// arithmetic unit. The unit's operands are frozen and its op is forced to nop
// (2'b11) whenever no work is pending. After SETTLE cycles the unit's result
// is captured and offered downstream over a valid/ready interface.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         request handshake (in_ready is combinational)
//   in_a, in_b, in_op         request operands and op (00 add, 01 sub, 10 mul, 11 nop)
//   alu_a, alu_b, alu_op      registered operands/op to the unit
//   alu_result                combinational result from the unit
//   out_valid/out_ready       result handshake
//   out_result, out_op        captured result and its op code
//   busy                      FSM not idle or FIFO not empty
//   stat_ops, stat_stall      saturating counters, only with LPA_ISSUE_STATS_EN
//
// Optional feature macro: LPA_ISSUE_STATS_EN
module lpa_issue_ctrl #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [1:0]           alu_op,
    input  logic [2*WIDTH-1:0]   alu_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_result,
    output logic [1:0]           out_op,
    output logic                 busy
`ifdef LPA_ISSUE_STATS_EN
    ,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_stall
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [1:0]  OP_NOP = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [1:0]       op;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t          state;
    req_t            mem [DEPTH];
    req_t            head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   cnt;
    logic            push;
    logic            pop;

    // Request handshake and FIFO pop decision
    assign in_ready = !rst && (count < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign busy     = (state != IDLE) || (count != '0);

    always_comb begin
        pop = 1'b0;
        if (count != '0) begin
            pop = (state == IDLE) || ((state == HOLD) && out_ready);
        end
    end

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: in_a, b: in_b, op: in_op};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue FSM; a pop always loads the head straight into ISSUE
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_NOP;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_op     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        alu_a  <= head.a;
                        alu_b  <= head.b;
                        alu_op <= head.op;
                        cnt    <= SW'(SETTLE - 1);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - SW'(1);
                    end else begin
                        // a nop never trusts the unit's output
                        out_result <= (alu_op == OP_NOP) ? '0 : alu_result;
                        out_op     <= alu_op;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (pop) begin
                            alu_a  <= head.a;
                            alu_b  <= head.b;
                            alu_op <= head.op;
                            cnt    <= SW'(SETTLE - 1);
                            state  <= ISSUE;
                        end else begin
                            alu_op <= OP_NOP;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LPA_ISSUE_STATS_EN
    // Saturating handshake and stall counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (out_valid && out_ready && (stat_ops != 16'hFFFF)) begin
                stat_ops <= stat_ops + 16'd1;
            end
            if (out_valid && !out_ready && (stat_stall != 16'hFFFF)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lpa_issue_ctrl.sv
// Testbench for lpa_issue_ctrl: directed requests, a queue-based reference of
// expected results, and per-cycle checks of ordering, busy, isolation and
// output stability. Stats checks are built only with LPA_ISSUE_STATS_EN.
module tb_lpa_issue_ctrl;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SETTLE = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_a;
    logic [7:0]        in_b;
    logic [1:0]        in_op;
    logic [7:0]        alu_a;
    logic [7:0]        alu_b;
    logic [1:0]        alu_op;
    logic [15:0]       alu_result;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_result;
    logic [1:0]        out_op;
    logic              busy;
`ifdef LPA_ISSUE_STATS_EN
    logic [15:0]       stat_ops;
    logic [15:0]       stat_stall;
`endif

    always #5 clk = ~clk;

    lpa_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_op     (out_op),
        .busy       (busy)
`ifdef LPA_ISSUE_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall)
`endif
    );

    // External arithmetic unit; nop returns junk that must never be captured
    always_comb begin
        case (alu_op)
            2'b00:   alu_result = 16'(alu_a) + 16'(alu_b);
            2'b01:   alu_result = 16'(alu_a) - 16'(alu_b);
            2'b10:   alu_result = 16'(alu_a) * 16'(alu_b);
            default: alu_result = 16'hDEAD;
        endcase
    end

    typedef struct {
        logic [15:0] res;
        logic [1:0]  op;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors    = 0;
    int          miscompares = 0;
    int          cyc        = 0;
    int          hs_n       = 0;
    logic [15:0] hs_res [64];
    logic [1:0]  hs_op  [64];
    int          hs_cyc [64];
    bit          armed     = 1'b0;
    bit          hold_prev = 1'b0;
    bit          idle_prev = 1'b0;
    logic [15:0] held_res;
    logic [1:0]  held_op;
    logic [7:0]  prev_a;
    logic [7:0]  prev_b;
    logic [15:0] m_ops   = '0;
    logic [15:0] m_stall = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Reference result of a request from its operands alone
    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return 16'(a) + 16'(b);
            2'b01:   return 16'(a) - 16'(b);
            2'b10:   return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare; at a negedge the sampled handshakes happen at the next edge
    always @(negedge clk) begin
        if (armed && !rst) begin
            check("busy", 32'(busy), 32'(sb.size() != 0));
            if (sb.size() == 0) check("iso_op", 32'(alu_op), 32'h3);
            if (idle_prev && sb.size() == 0) begin
                check("iso_a", 32'(alu_a), 32'(prev_a));
                check("iso_b", 32'(alu_b), 32'(prev_b));
            end
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'h1);
                check("hold_res", 32'(out_result), 32'(held_res));
                check("hold_op", 32'(out_op), 32'(held_op));
            end
`ifdef LPA_ISSUE_STATS_EN
            check("stat_ops", 32'(stat_ops), 32'(m_ops));
            check("stat_stall", 32'(stat_stall), 32'(m_stall));
            if (out_valid && out_ready && m_ops != 16'hFFFF) m_ops = m_ops + 16'd1;
            if (out_valid && !out_ready && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
            hold_prev = 1'b0;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    e = sb.pop_front();
                    check("result", 32'(out_result), 32'(e.res));
                    check("op", 32'(out_op), 32'(e.op));
                end
                if (hs_n < 64) begin
                    hs_res[hs_n] = out_result;
                    hs_op[hs_n]  = out_op;
                    hs_cyc[hs_n] = cyc;
                end
                hs_n++;
            end else if (out_valid) begin
                hold_prev = 1'b1;
                held_res  = out_result;
                held_op   = out_op;
            end
            if (in_valid && in_ready) sb.push_back('{model(in_a, in_b, in_op), in_op});
            idle_prev = (sb.size() == 0);
            prev_a    = alu_a;
            prev_b    = alu_b;
        end else begin
            if (armed) check("in_ready_rst", 32'(in_ready), 32'h0);
            sb.delete();
            hold_prev = 1'b0;
            idle_prev = 1'b0;
            m_ops     = '0;
            m_stall   = '0;
        end
        if (rst) armed = 1'b1;
    end

    // Present a request until accepted; leaves in_valid high
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        bit got = 1'b0;
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!got && n < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!got) fail_now("send_timeout");
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_n < target && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (hs_n < target) fail_now("handshake_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_alu_a", 32'(alu_a), 32'h0);
        check("rst_alu_b", 32'(alu_b), 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'h3);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_result", 32'(out_result), 32'h0);
        check("rst_out_op", 32'(out_op), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", 32'(in_ready), 32'h1);
        check("t1_idle_op", 32'(alu_op), 32'h3);

        // Single add: out_valid visible after edge T0+2
        @(posedge clk);
        #1;
        send(8'h0A, 8'h05, 2'b00);
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_lat0", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("t1_lat1", 32'(out_valid), 32'h0);
        @(negedge clk);
        check("t1_valid", 32'(out_valid), 32'h1);
        check("t1_result", 32'(out_result), 32'h000F);
        check("t1_op", 32'(out_op), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_after_op", 32'(alu_op), 32'h3);
        check("t1_after_valid", 32'(out_valid), 32'h0);
        check("t1_after_busy", 32'(busy), 32'h0);

        // Back-to-back sequence, one result every SETTLE+1 cycles
        @(posedge clk);
        #1;
        base = hs_n;
        send(8'h14, 8'h08, 2'b01);
        send(8'h80, 8'h80, 2'b10);
        send(8'hFF, 8'h01, 2'b00);
        in_valid = 1'b0;
        wait_hs(base + 3);
        if (hs_n >= base + 3) begin
            check("t2_r0", 32'(hs_res[base]), 32'h000C);
            check("t2_r1", 32'(hs_res[base+1]), 32'h4000);
            check("t2_r2", 32'(hs_res[base+2]), 32'h0100);
            check("t2_op0", 32'(hs_op[base]), 32'h1);
            check("t2_op1", 32'(hs_op[base+1]), 32'h2);
            check("t2_op2", 32'(hs_op[base+2]), 32'h0);
            check("t2_gap01", 32'(hs_cyc[base+1] - hs_cyc[base]), 32'd2);
            check("t2_gap12", 32'(hs_cyc[base+2] - hs_cyc[base+1]), 32'd2);
        end

        // Backpressure: one request in HOLD plus four buffered fills the FIFO
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        base = hs_n;
        send(8'h01, 8'h02, 2'b00);
        send(8'h03, 8'h01, 2'b01);
        send(8'h02, 8'h03, 2'b10);
        send(8'h01, 8'h03, 2'b01);
        send(8'h04, 8'h04, 2'b00);
        in_a = 8'h09; in_b = 8'h09; in_op = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_full_in_ready", 32'(in_ready), 32'h0);
            check("t3_stall_valid", 32'(out_valid), 32'h1);
            check("t3_stall_result", 32'(out_result), 32'h0003);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_hs(base + 5);
        if (hs_n >= base + 5) begin
            check("t3_r0", 32'(hs_res[base]), 32'h0003);
            check("t3_r1", 32'(hs_res[base+1]), 32'h0002);
            check("t3_r2", 32'(hs_res[base+2]), 32'h0006);
            check("t3_r3", 32'(hs_res[base+3]), 32'hFFFE);
            check("t3_r4", 32'(hs_res[base+4]), 32'h0008);
        end

        // Nop captures zero regardless of the unit's output
        @(posedge clk);
        #1;
        base = hs_n;
        send(8'h01, 8'h01, 2'b11);
        in_valid = 1'b0;
        wait_hs(base + 1);
        if (hs_n >= base + 1) begin
            check("t4_nop_res", 32'(hs_res[base]), 32'h0000);
            check("t4_nop_op", 32'(hs_op[base]), 32'h3);
        end
        @(negedge clk);
        check("t4_idle_op", 32'(alu_op), 32'h3);

        // Reset while in ISSUE with two entries queued
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(8'h02, 8'h02, 2'b00);
        send(8'h05, 8'h03, 2'b01);
        send(8'h06, 8'h07, 2'b10);
        send(8'h01, 8'h01, 2'b00);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("t5_in_issue_valid", 32'(out_valid), 32'h0);
        check("t5_in_issue_busy", 32'(busy), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_valid", 32'(out_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_alu_op", 32'(alu_op), 32'h3);
        check("t5_in_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_pulse", 32'(out_valid), 32'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        base = hs_n;
        send(8'h30, 8'h50, 2'b10);
        in_valid = 1'b0;
        wait_hs(base + 1);
        if (hs_n >= base + 1) check("t5_new_res", 32'(hs_res[base]), 32'h0F00);

`ifdef LPA_ISSUE_STATS_EN
        // Three completed ops with four stall cycles after a clearing reset
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        base = hs_n;
        send(8'h01, 8'h01, 2'b00);
        send(8'h02, 8'h02, 2'b00);
        send(8'h03, 8'h03, 2'b00);
        in_valid = 1'b0;
        begin
            int n = 0;
            bit seen = 1'b0;
            while (!seen && n < 50) begin
                @(negedge clk);
                seen = out_valid;
                n++;
            end
            if (!seen) fail_now("stats_valid_timeout");
        end
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_hs(base + 3);
        @(negedge clk);
        check("stat_ops_final", 32'(stat_ops), 32'd3);
        check("stat_stall_final", 32'(stat_stall), 32'd4);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lpa_issue_ctrl.md
Name: lpa_issue_ctrl

Overview:
Upstream issue stage for the LowPowerArithmetic datapath. It accepts operation requests over a valid/ready interface and buffers them in a small FIFO. It drives operands to the combinational arithmetic unit with operand isolation, so the unit's inputs stay frozen and op is idle whenever no work is pending. It captures the unit's result after a programmable settle time and presents it downstream through a valid/ready interface.

Parameters:
WIDTH, 8, operand width; result width is 2*WIDTH
DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2
SETTLE, 1, cycles the operands are held on the unit before the result is captured; must be at least 1

Ports:
clk  input  1  clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid and in_ready are both high at an edge
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  2  00 add, 01 sub, 10 mul, 11 nop
alu_a  output  WIDTH  registered operand A to the unit
alu_b  output  WIDTH  registered operand B to the unit
alu_op  output  2  registered op to the unit; 11 when idle
alu_result  input  2*WIDTH  combinational result from the unit
out_valid  output  1  result valid
out_ready  input  1  downstream ready
out_result  output  2*WIDTH  captured result
out_op  output  2  op code belonging to out_result
busy  output  1  high when the FSM is not in IDLE or the FIFO is not empty

Behaviour:
- One clock domain; reset is synchronous and active-high. Clock port clk, reset port rst.
- Reset values: alu_a=0, alu_b=0, alu_op=2'b11, out_valid=0, out_result=0, out_op=0, busy=0. The FIFO is emptied.
- in_ready = !rst && (fifo_count < DEPTH), combinational.
  - No push when full, even if a pop happens on the same edge.
  - Push and pop on the same edge when not full: count is unchanged.
- FSM states: IDLE, ISSUE, HOLD.
- IDLE:
  - alu_a and alu_b hold their last values; alu_op = 11 (isolation).
  - If the FIFO is non-empty at an edge: pop the head, load alu_a, alu_b and alu_op, load cnt = SETTLE-1, go to ISSUE.
- ISSUE:
  - If cnt != 0, decrement cnt.
  - If cnt == 0: out_result <= alu_result, out_op <= alu_op, out_valid <= 1, go to HOLD.
  - A nop request (op 11) passes through ISSUE the same way but captures out_result = 0, not alu_result.
- HOLD:
  - alu_a, alu_b and alu_op stay frozen.
  - On an edge with out_ready=1: out_valid <= 0. If the FIFO is non-empty, pop and load directly into ISSUE (back-to-back, no IDLE cycle). Otherwise go to IDLE and set alu_op <= 11.
  - out_result and out_op must not change while out_valid=1 and out_ready=0.
- Latency: a request accepted at edge T0 with an empty FIFO and the FSM in IDLE has out_valid high after edge T0+1+SETTLE.
- Throughput: with out_ready tied high, one result every SETTLE+1 cycles.
- The FIFO preserves order; out_op always matches its own request.
- Width: out_result is alu_result as delivered, with no truncation or extension. A sub underflow appears as a 2*WIDTH two's-complement value.
- Reset asserted mid-operation: on the next edge the in-flight op and all FIFO contents are discarded and all outputs return to reset values. No out_valid pulse is generated.
- busy falls in the same cycle the FSM enters IDLE with an empty FIFO.

Optional Feature:
- Macro LPA_ISSUE_STATS_EN.
- When defined, add output port stat_ops (16 bits) and output port stat_stall (16 bits):
  - stat_ops counts completed handshakes (out_valid && out_ready).
  - stat_stall counts cycles with out_valid && !out_ready.
  - Both saturate at 16'hFFFF and clear on rst.
- When undefined, neither port nor either counter exists, and all other behaviour is identical.

Test Plan:
- Add: reset, then a=0x0A, b=0x05, op=00 with out_ready=1 -> out_valid 2 cycles after acceptance (SETTLE=1), out_result=0x000F, out_op=00. alu_op=11 before the request and after completion.
- Sequence: back-to-back requests 0x14-0x08 (op 01), 0x80*0x80 (op 10), 0xFF+0x01 (op 00), out_ready=1 -> in-order results 0x000C, 0x4000, 0x0100, one every 2 cycles.
- Backpressure: out_ready=0, push 5 requests with DEPTH=4 ->
  - in_ready drops after the FIFO fills (1 request held in HOLD plus 4 buffered).
  - out_result stays stable.
  - After releasing out_ready, all 5 results arrive in order.
- Nop and isolation: push 0x01, 0x01, op=11 -> out_result=0x0000, out_op=11. alu_a and alu_b never toggle during IDLE.
- Reset: assert rst while in ISSUE with 2 entries queued -> no out_valid, busy=0 and alu_op=11 after the edge. A new request afterwards gives the correct result.
- Stats (with LPA_ISSUE_STATS_EN): 3 ops with 4 stall cycles -> stat_ops=3, stat_stall=4.
